// File: rtl/accu_result_fifo.sv
// rtl/accu_result_fifo.sv - circular result buffer behind the 50-sample accumulator
//
// Captures one signed window sum per rising edge of the accumulator's
// data_valid and presents the oldest stored sum first-word-fall-through
// on a valid/ready handshake.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   din        - signed window sum from the accumulator
//   din_valid  - accumulator data_valid (may be held high for several cycles)
//   dout       - oldest stored sum (0 while empty)
//   dout_valid - dout holds a valid entry
//   dout_ready - consumer accepts dout when dout_valid is also high
//   count      - stored entries, 0..DEPTH
//   full       - count == DEPTH
//   empty      - count == 0
//   overflow   - sticky, set when a capture is dropped
//   ovf_clr    - synchronous clear of overflow (a same-cycle drop wins)
module accu_result_fifo #(
    parameter int DATA_W = 37,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic signed [DATA_W-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic signed [DATA_W-1:0] mem_q [DEPTH];

    logic              din_valid_q, din_valid_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic push;
    logic pop;
    logic do_write;
    logic drop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign dout_valid = ~empty;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign dout       = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // A held data_valid yields a single capture on its rising edge.
        push = din_valid & ~din_valid_q;
        pop  = dout_valid & dout_ready;

        // A full buffer still accepts a capture when a pop frees a slot
        // in the same cycle.
        do_write = push & (~full | pop);
        drop     = push & full & ~pop;

        din_valid_d = din_valid;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        if (do_write && !pop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (pop && !do_write) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end

        // Set has priority over clear so a lost window is never hidden.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            din_valid_q <= din_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset; empty masks stale contents on dout.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_accu_result_fifo.sv
// tb/tb_accu_result_fifo.sv - self-checking bench for accu_result_fifo
module tb_accu_result_fifo;

    localparam int DATA_W = 37;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic                     clk;
    logic                     rst;
    logic signed [DATA_W-1:0] din;
    logic                     din_valid;
    logic signed [DATA_W-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [ADDR_W:0]          count;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     ovf_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of stored results plus the flag.
    logic signed [DATA_W-1:0] mq[$];
    logic                     m_ovf;
    logic                     m_prev;

    accu_result_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, 64'(count), 64'(sz));
        chk({tag, ".empty"}, 64'(empty), 64'(sz == 0));
        chk({tag, ".full"}, 64'(full), 64'(sz == DEPTH));
        chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(sz != 0));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        if (sz != 0) chk({tag, ".dout"}, 64'(dout), 64'(mq[0]));
        else         chk({tag, ".dout"}, 64'(dout), 64'sd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b0;
    endtask

    // Advance one clock with the current inputs, updating the model first.
    task automatic cycle(input string tag);
        int   sz;
        logic push, pop, drop;
        sz   = mq.size();
        push = din_valid & ~m_prev;
        pop  = (sz != 0) & dout_ready;
        drop = 1'b0;
        if (pop) mq.delete(0);
        if (push) begin
            if (sz < DEPTH || pop) mq.push_back(din);
            else drop = 1'b1;
        end
        if (drop)         m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_prev = din_valid;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic push_one(input logic signed [DATA_W-1:0] v, input string tag);
        din       = v;
        din_valid = 1'b1;
        cycle(tag);
        din_valid = 1'b0;
        cycle(tag);
    endtask

    task automatic drain(input string tag);
        dout_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle(tag);
        dout_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        ovf_clr    = 1'b0;
        model_reset();
        #2;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        cycle("post_reset");

        // Single window and one-cycle latency.
        din       = 37'sd1225;
        din_valid = 1'b1;
        cycle("single_capture");
        chk("single_dout", 64'(dout), 64'sd1225);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        cycle("single_pop");
        chk("single_empty", 64'(empty), 64'sd1);
        dout_ready = 1'b0;

        // Held data_valid gives one entry.
        din       = -37'sd300;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) cycle("held");
        din_valid = 1'b0;
        cycle("held_end");
        chk("held_count", 64'(count), 64'sd1);
        chk("held_dout", 64'(dout), -64'sd300);
        drain("held_drain");

        // Fill, overflow, ordered drain without the dropped value.
        for (int i = 1; i <= 17; i++) push_one(DATA_W'(i), "fill");
        chk("fill_full", 64'(full), 64'sd1);
        chk("fill_ovf", 64'(overflow), 64'sd1);
        dout_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("fill_order", 64'(dout), 64'(i));
            cycle("fill_drain");
        end
        dout_ready = 1'b0;
        chk("fill_drained", 64'(empty), 64'sd1);
        ovf_clr = 1'b1;
        cycle("ovf_clr");
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'sd0);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 16; i++) push_one(DATA_W'(i), "refill");
        din        = 37'sd99;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        cycle("full_push_pop");
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        chk("fpp_count", 64'(count), 64'sd16);
        chk("fpp_ovf", 64'(overflow), 64'sd0);
        chk("fpp_head", 64'(dout), 64'sd2);
        drain("fpp_drain");

        // Pointer wrap with alternating signs.
        for (int i = 0; i < 40; i++) begin
            din       = (i % 2 == 0) ? DATA_W'(5 + i) : -DATA_W'(5 + i);
            din_valid = 1'b1;
            cycle("wrap_push");
            din_valid  = 1'b0;
            dout_ready = 1'b1;
            cycle("wrap_pop");
            dout_ready = 1'b0;
        end

        // Clear coinciding with an overflow: the set wins.
        for (int i = 0; i < 16; i++) push_one(DATA_W'(-i), "ovf_fill");
        din       = 37'sd7;
        din_valid = 1'b1;
        ovf_clr   = 1'b1;
        cycle("ovf_set_vs_clr");
        din_valid = 1'b0;
        ovf_clr   = 1'b0;
        chk("ovf_set_wins", 64'(overflow), 64'sd1);
        ovf_clr = 1'b1;
        cycle("ovf_clr2");
        ovf_clr = 1'b0;
        drain("ovf_drain");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            din        = DATA_W'({$urandom(), $urandom()});
            din_valid  = ($urandom_range(0, 2) != 0);
            dout_ready = ($urandom_range(0, 3) == 0);
            ovf_clr    = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        ovf_clr    = 1'b0;
        cycle("rand_end");
        drain("rand_drain");

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 7; i++) push_one(DATA_W'(100 + i), "pre_rst");
        chk("pre_rst_count", 64'(count), 64'sd7);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("rst_release");
        push_one(-37'sd4242, "post_rst_push");
        chk("post_rst_dout", 64'(dout), -64'sd4242);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accu_result_fifo.md
Name: accu_result_fifo

Overview:
- Buffers the signed window sums produced by the upstream 50-sample accumulator.
- Captures one result per accumulation window, on the rising edge of the accumulator's data_valid, and stores it in a circular buffer.
- Presents the oldest result to the downstream consumer on a valid/ready handshake.
- Reports occupancy and a sticky overflow flag so software or control logic can detect lost windows.

Parameters:
- DATA_W, 37, width of one accumulated result (matches accumulator output width).
- DEPTH, 16, number of storage entries; must be a power of two and at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- din  input  DATA_W  signed window sum from the accumulator dout.
- din_valid  input  1  accumulator data_valid; may stay high for several cycles while the accumulator holds.
- dout  output  DATA_W  signed oldest stored result.
- dout_valid  output  1  high when dout holds a valid entry.
- dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both high at a clock edge.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set when a capture is dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout_valid=0, overflow=0, din_valid_d=0.
  - dout reads 0 while empty. Memory contents are don't-care.
- Edge detect:
  - din_valid_d is a registered copy of din_valid.
  - push = din_valid & ~din_valid_d.
  - A multi-cycle high din_valid produces exactly one push.
  - din_valid already high in the first cycle after reset release produces one push.
- Pop: pop = dout_valid & dout_ready.
- Write on push (not full, or full with a simultaneous pop):
  - mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read on pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- First-word fall-through output:
  - dout = mem[rd_ptr] whenever not empty; dout_valid = ~empty.
  - Latency: din_valid rises in cycle N, entry is captured at the end of cycle N, dout_valid=1 and dout=din in cycle N+1.
- Boundary conditions:
  - Full + push + pop: both performed; count stays DEPTH; no overflow.
  - Full + push, no pop: din dropped; pointers and count unchanged; overflow <= 1.
  - Empty + dout_ready: no pop; rd_ptr unchanged. dout_ready is ignored when dout_valid=0.
  - Empty + push: entry written; pop impossible that cycle because dout_valid=0.
  - Pointer wrap: after DEPTH writes, wr_ptr returns to 0. Data order is preserved across the wrap.
  - ovf_clr=1 clears overflow. If ovf_clr=1 and an overflow event occur in the same cycle, the set wins and overflow stays 1.
  - Reset mid-operation: all stored data discarded; outputs return to reset values asynchronously.
- Arithmetic: data stored and passed verbatim, signed, with no extension or truncation. count is unsigned.
- Handshake stability: while dout_valid=1 and dout_ready=0, dout and dout_valid hold stable. A push into a non-empty FIFO does not alter dout.

Test Plan:
- Reset then single window: din=37'sd1225, din_valid high for 1 cycle -> next cycle dout_valid=1, dout=1225, count=1; dout_ready=1 one cycle -> empty=1, count=0.
- Held data_valid: din_valid high for 5 consecutive cycles with din=-300 -> exactly one entry (count=1), dout=-300.
- Fill and overflow: 17 rising-edge pushes of values 1..17 with dout_ready=0 -> full=1 after the 16th, count=16, overflow=1; draining yields 1..16 in order, and 17 is absent.
- Full with simultaneous push/pop: FIFO full holding 1..16, push 99 while dout_ready=1 -> 1 popped, count=16, overflow unchanged (0), final drain order 2..16,99.
- Wrap and ovf_clr: 40 push/pop pairs of alternating +/- values (e.g. 5,-5,...) -> output order matches input across pointer wrap; raise ovf_clr after an overflow -> overflow=0 next cycle; ovf_clr in the same cycle as an overflow -> overflow=1.
- Async reset mid-stream: 7 entries stored, rst=0 between clock edges -> count=0, dout_valid=0, empty=1 immediately, no clock edge needed; after release, the first new push reads back correctly.
